tcpc_tx_protocol: RTL and testbench

- Transmit-side protocol layer of the TCPC; the counterpart of the RX/GoodCRC path.
- On a TRANSMIT register write it builds the 16-bit PD message header from TX_BUF_HEADER_BYTE_0/1 and MESSAGE_HEADER_INFO, inserting the per-SOP MessageID.
- It drives the PHY transmitter, waits for a matching GoodCRC, and retries on CRCReceiveTimer expiry.
- It reports TRANSMIT_SUCCESSFUL, TRANSMIT_FAILED or TRANSMIT_DISCARDED as sticky alert bits.

---
 rtl/tcpc_tx_protocol.sv | 220 ++++++++++++++++++++++
 tb/tb_tcpc_tx_protocol.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcpc_tx_protocol.sv
// TCPC transmit protocol layer: builds the PD message header on a TRANSMIT
// write, drives the PHY transmitter, waits for a matching GoodCRC with
// CRCReceiveTimer-based retries, and raises sticky success/fail/discard alerts.
`timescale 1ns / 1ps

module tcpc_tx_protocol #(
  parameter int unsigned CRC_TIMER_CYCLES = 900,
  parameter int unsigned TIMER_W          = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        transmit_write,
  input  logic [7:0]  TRANSMIT,
  input  logic [7:0]  TX_BUF_HEADER_BYTE_0,
  input  logic [7:0]  TX_BUF_HEADER_BYTE_1,
  input  logic [7:0]  MESSAGE_HEADER_INFO,
  input  logic        rx_sop_detect,
  input  logic        phy_tx_done,
  input  logic        phy_rx_goodcrc,
  input  logic [2:0]  goodcrc_msg_id,
  input  logic [2:0]  alert_clear,
  output logic        phy_tx_start,
  output logic [2:0]  phy_tx_sop,
  output logic [15:0] tx_header,
  output logic        tx_busy,
  output logic        TRANSMIT_SUCCESSFUL,
  output logic        TRANSMIT_FAILED,
  output logic        TRANSMIT_DISCARDED
);

  typedef enum logic [2:0] {
    StIdle,
    StConstruct,
    StSend,
    StWaitDone,
    StWaitGoodcrc,
    StReport
  } state_e;

  // Report codes share the bit order of alert_clear: {discarded, failed, successful}.
  localparam logic [2:0] RptSuccess = 3'b001;
  localparam logic [2:0] RptFailed  = 3'b010;
  localparam logic [2:0] RptDiscard = 3'b100;

  localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(CRC_TIMER_CYCLES - 1);

  state_e              state_q, state_d;
  logic [2:0]          sop_q;
  logic [1:0]          nretry_q;
  logic [1:0]          retry_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [15:0]         header_q;
  logic [2:0]          rpt_q;
  logic [2:0]          alert_q;
  logic [2:0]          msg_id_q [3];

  logic [2:0]          cur_id;
  logic [15:0]         header_d;
  logic                is_reset_sop;
  logic                is_sop;
  logic                is_sop_prime;
  logic                discard;
  logic                goodcrc_match;
  logic                timeout;
  logic                retry_ok;
  logic [2:0]          alert_set;

  // Reserved register bits that this layer does not interpret.
  logic unused_bits;
  assign unused_bits = ^{TRANSMIT[7:6], TRANSMIT[3], TX_BUF_HEADER_BYTE_0[7:5],
                         TX_BUF_HEADER_BYTE_1[3:0], MESSAGE_HEADER_INFO[7:5]};

  // Decode of the latched request and of the GoodCRC/timer events.
  always_comb begin
    cur_id = 3'd0;
    case (sop_q)
      3'd0:    cur_id = msg_id_q[0];
      3'd1:    cur_id = msg_id_q[1];
      3'd2:    cur_id = msg_id_q[2];
      default: cur_id = 3'd0;  // debug/reset SOPs carry no MessageID counter
    endcase
    is_sop        = (sop_q == 3'd0);
    is_sop_prime  = (sop_q == 3'd1) || (sop_q == 3'd2);
    is_reset_sop  = (sop_q == 3'd5) || (sop_q == 3'd6);
    // Hard/cable reset is sent even if the line is busy with an incoming message.
    discard       = (sop_q == 3'd7) || (rx_sop_detect && !is_reset_sop);
    goodcrc_match = phy_rx_goodcrc && (goodcrc_msg_id == cur_id);
    timeout       = (timer_q == TimerLast);
    retry_ok      = (retry_q < nretry_q);
  end

  // Header assembly from the TX buffer bytes and MESSAGE_HEADER_INFO.
  always_comb begin
    header_d        = 16'h0000;
    header_d[4:0]   = TX_BUF_HEADER_BYTE_0[4:0];
    header_d[5]     = is_sop ? MESSAGE_HEADER_INFO[3] : 1'b0;
    header_d[7:6]   = MESSAGE_HEADER_INFO[2:1];
    header_d[8]     = is_sop       ? MESSAGE_HEADER_INFO[0] :
                      is_sop_prime ? MESSAGE_HEADER_INFO[4] : 1'b0;
    header_d[11:9]  = cur_id;
    header_d[15:12] = TX_BUF_HEADER_BYTE_1[7:4];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:        if (transmit_write) state_d = StConstruct;
      StConstruct:   state_d = discard ? StReport : StSend;
      StSend:        state_d = StWaitDone;
      StWaitDone: begin
        if (phy_tx_done) state_d = is_reset_sop ? StReport : StWaitGoodcrc;
      end
      StWaitGoodcrc: begin
        // A matching GoodCRC beats a simultaneous timer expiry.
        if (goodcrc_match) begin
          state_d = StReport;
        end else if (timeout) begin
          state_d = retry_ok ? StSend : StReport;
        end
      end
      StReport:      state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  // Request latch, header, timer, retry counter, MessageIDs and report code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sop_q       <= 3'd0;
      nretry_q    <= 2'd0;
      retry_q     <= 2'd0;
      timer_q     <= '0;
      header_q    <= 16'h0000;
      rpt_q       <= 3'd0;
      msg_id_q[0] <= 3'd0;
      msg_id_q[1] <= 3'd0;
      msg_id_q[2] <= 3'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (transmit_write) begin
            sop_q    <= TRANSMIT[2:0];
            nretry_q <= TRANSMIT[5:4];
          end
        end
        StConstruct: begin
          header_q <= header_d;
          if (discard) rpt_q <= RptDiscard;
        end
        StWaitDone: begin
          if (phy_tx_done) begin
            timer_q <= '0;
            if (is_reset_sop) begin
              rpt_q       <= RptSuccess;
              msg_id_q[0] <= 3'd0;
              msg_id_q[1] <= 3'd0;
              msg_id_q[2] <= 3'd0;
            end
          end
        end
        StWaitGoodcrc: begin
          timer_q <= timer_q + 1'b1;
          if (goodcrc_match) begin
            rpt_q <= RptSuccess;
            case (sop_q)
              3'd0:    msg_id_q[0] <= msg_id_q[0] + 3'd1;
              3'd1:    msg_id_q[1] <= msg_id_q[1] + 3'd1;
              3'd2:    msg_id_q[2] <= msg_id_q[2] + 3'd1;
              default: ;
            endcase
          end else if (timeout) begin
            if (retry_ok) begin
              retry_q <= retry_q + 2'd1;
            end else begin
              rpt_q <= RptFailed;
            end
          end
        end
        StReport: retry_q <= 2'd0;
        default: ;
      endcase
    end
  end

  // Sticky alerts; a set wins over a clear in the same cycle.
  always_comb begin
    alert_set = (state_q == StReport) ? rpt_q : 3'd0;
  end

  // Alert register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alert_q <= 3'd0;
    end else begin
      alert_q <= alert_set | (alert_q & ~alert_clear);
    end
  end

  // FSM and datapath outputs.
  always_comb begin
    phy_tx_start        = (state_q == StSend);
    phy_tx_sop          = sop_q;
    tx_header           = header_q;
    tx_busy             = (state_q != StIdle);
    TRANSMIT_SUCCESSFUL = alert_q[0];
    TRANSMIT_FAILED     = alert_q[1];
    TRANSMIT_DISCARDED  = alert_q[2];
  end

endmodule

// File: tb/tb_tcpc_tx_protocol.sv
// Bench for tcpc_tx_protocol: directed scenarios plus randomized transactions
// checked against a transaction-level model of MessageIDs, headers and alerts.
`timescale 1ns / 1ps

module tb_tcpc_tx_protocol;

  localparam int unsigned CRC = 40;
  localparam int unsigned TW  = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        transmit_write;
  logic [7:0]  transmit;
  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic [7:0]  hdr_info;
  logic        rx_sop_detect;
  logic        phy_tx_done;
  logic        phy_rx_goodcrc;
  logic [2:0]  goodcrc_msg_id;
  logic [2:0]  alert_clear;
  logic        phy_tx_start;
  logic [2:0]  phy_tx_sop;
  logic [15:0] tx_header;
  logic        tx_busy;
  logic        succ, fail, disc;
  logic [2:0]  alerts;

  assign alerts = {disc, fail, succ};

  always #5 clk = ~clk;

  tcpc_tx_protocol #(
    .CRC_TIMER_CYCLES(CRC),
    .TIMER_W         (TW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .transmit_write      (transmit_write),
    .TRANSMIT            (transmit),
    .TX_BUF_HEADER_BYTE_0(byte0),
    .TX_BUF_HEADER_BYTE_1(byte1),
    .MESSAGE_HEADER_INFO (hdr_info),
    .rx_sop_detect       (rx_sop_detect),
    .phy_tx_done         (phy_tx_done),
    .phy_rx_goodcrc      (phy_rx_goodcrc),
    .goodcrc_msg_id      (goodcrc_msg_id),
    .alert_clear         (alert_clear),
    .phy_tx_start        (phy_tx_start),
    .phy_tx_sop          (phy_tx_sop),
    .tx_header           (tx_header),
    .tx_busy             (tx_busy),
    .TRANSMIT_SUCCESSFUL (succ),
    .TRANSMIT_FAILED     (fail),
    .TRANSMIT_DISCARDED  (disc)
  );

  int checks = 0;
  int errors = 0;

  // Model state and per-transaction expectations.
  int          msg_id_m [3];
  int          exp_starts;
  logic [2:0]  exp_set;
  logic [15:0] exp_hdr;
  logic [2:0]  exp_good;

  // Observations from the last driven transaction.
  int          obs_starts;
  int          obs_lat;
  int          obs_bad_gap;
  logic [15:0] obs_hdr;
  bit          obs_same;
  bit          obs_hung;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_alerts();
    alert_clear = 3'b111;
    tick();
    alert_clear = 3'b000;
  endtask

  function automatic logic [15:0] model_header(input int sop, input logic [7:0] mhi,
                                                input logic [7:0] b0, input logic [7:0] b1,
                                                input int id);
    int v;
    int role;
    v = int'(b0 % 32) + int'(mhi[2:1]) * 64 + id * 512 + int'(b1 / 16) * 4096;
    if (sop == 0) begin
      v  = v + int'(mhi[3]) * 32;
      role = int'(mhi[0]);
    end else if (sop == 1 || sop == 2) begin
      role = int'(mhi[4]);
    end else begin
      role = 0;
    end
    v = v + role * 256;
    return 16'(v);
  endfunction

  // Transaction-level outcome: ok_att is the attempt index that gets a GoodCRC (-1: never).
  task automatic model_txn(input logic [7:0] tr, input logic [7:0] mhi, input logic [7:0] b0,
                           input logic [7:0] b1, input int ok_att, input bit rx_sop);
    int sop;
    int nr;
    int cur;
    sop = int'(tr[2:0]);
    nr  = int'(tr[5:4]);
    cur = (sop < 3) ? msg_id_m[sop] : 0;
    exp_hdr  = model_header(sop, mhi, b0, b1, cur);
    exp_good = 3'(cur);
    if (sop == 7 || (rx_sop && sop != 5 && sop != 6)) begin
      exp_starts = 0;
      exp_set    = 3'b100;
    end else if (sop == 5 || sop == 6) begin
      exp_starts = 1;
      exp_set    = 3'b001;
      msg_id_m   = '{0, 0, 0};
    end else if (ok_att >= 0 && ok_att <= nr) begin
      exp_starts = ok_att + 1;
      exp_set    = 3'b001;
      if (sop < 3) msg_id_m[sop] = (cur + 1) % 8;
    end else begin
      exp_starts = nr + 1;
      exp_set    = 3'b010;
    end
  endtask

  // Drives one full request and records what the DUT did; returns once idle.
  task automatic run_txn(input logic [7:0] tr, input logic [7:0] mhi, input logic [7:0] b0,
                         input logic [7:0] b1, input int ok_att, input int ok_wait,
                         input bit rx_sop, input bit noise_en, input logic [2:0] noise_xor);
    int  g;
    int  el;
    bit  rst_sop;
    model_txn(tr, mhi, b0, b1, ok_att, rx_sop);
    rst_sop     = (tr[2:0] == 3'd5) || (tr[2:0] == 3'd6);
    obs_starts  = 0;
    obs_hdr     = 16'h0;
    obs_same    = 1'b1;
    obs_hung    = 1'b0;
    obs_bad_gap = 0;
    hdr_info = mhi; byte0 = b0; byte1 = b1; transmit = tr;
    transmit_write = 1'b1;
    rx_sop_detect  = rx_sop;
    tick();
    transmit_write = 1'b0;
    obs_lat = 1;
    while (!phy_tx_start && tx_busy && obs_lat < 10) begin
      tick();
      obs_lat++;
    end
    rx_sop_detect = 1'b0;
    if (!phy_tx_start) begin
      if (tx_busy) obs_hung = 1'b1;
      return;
    end
    obs_hdr = tx_header;
    for (int a = 0; a < 8; a++) begin
      obs_starts++;
      if (tx_header !== obs_hdr || phy_tx_sop !== tr[2:0]) obs_same = 1'b0;
      tick();
      phy_tx_done = 1'b1;
      tick();
      phy_tx_done = 1'b0;
      el = 0;
      if (!rst_sop) begin
        if (noise_en && !(a == ok_att && ok_wait == 0)) begin
          phy_rx_goodcrc = 1'b1;
          goodcrc_msg_id = exp_good ^ noise_xor;
          tick();
          phy_rx_goodcrc = 1'b0;
          el = 1;
        end
        if (a == ok_att) begin
          while (el < ok_wait) begin
            tick();
            el++;
          end
          phy_rx_goodcrc = 1'b1;
          goodcrc_msg_id = exp_good;
          tick();
          phy_rx_goodcrc = 1'b0;
        end
      end
      g = el;
      while (!phy_tx_start && tx_busy && g < int'(CRC) + 10) begin
        tick();
        g++;
      end
      if (!tx_busy) return;
      if (!phy_tx_start) begin
        obs_hung = 1'b1;
        return;
      end
      if (g != int'(CRC)) obs_bad_gap++;
    end
    obs_hung = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    transmit_write = 1'b0; transmit = 8'h0; byte0 = 8'h0; byte1 = 8'h0; hdr_info = 8'h0;
    rx_sop_detect = 1'b0; phy_tx_done = 1'b0; phy_rx_goodcrc = 1'b0;
    goodcrc_msg_id = 3'd0; alert_clear = 3'd0;
    msg_id_m = '{0, 0, 0};
    repeat (3) tick();
    checks++;
    if ({phy_tx_start, phy_tx_sop, tx_header, tx_busy, alerts} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b sop=%0d hdr=%h busy=%b alerts=%b, want all 0",
               phy_tx_start, phy_tx_sop, tx_header, tx_busy, alerts);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_success();
    clear_alerts();
    run_txn(8'h00, 8'h1A, 8'h4B, 8'h27, 0, 3, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_lat !== 2) begin
      errors++; $display("FAIL success_latency: got %0d, want 2", obs_lat);
    end
    checks++;
    if (obs_hdr !== 16'h206B) begin
      errors++; $display("FAIL success_header: got %h, want 206b", obs_hdr);
    end
    checks++;
    if (obs_starts !== 1 || obs_hung) begin
      errors++; $display("FAIL success_starts: got %0d hung=%b, want 1", obs_starts, obs_hung);
    end
    checks++;
    if (alerts !== 3'b001) begin
      errors++; $display("FAIL success_alert: got %b, want 001", alerts);
    end
    clear_alerts();
    run_txn(8'h00, 8'h1A, 8'h4B, 8'h27, 0, 0, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_hdr[11:9] !== 3'd1) begin
      errors++; $display("FAIL success_second_id: got %0d, want 1", obs_hdr[11:9]);
    end
  endtask

  task automatic test_retries();
    logic [15:0] hdr_before;
    clear_alerts();
    run_txn(8'h20, 8'($urandom), 8'($urandom), 8'($urandom), -1, 0, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_starts !== 3 || obs_hung) begin
      errors++; $display("FAIL retry_starts: got %0d hung=%b, want 3", obs_starts, obs_hung);
    end
    checks++;
    if (obs_bad_gap !== 0 || !obs_same) begin
      errors++;
      $display("FAIL retry_timing_header: got bad_gaps=%0d same=%b, want 0 and 1",
               obs_bad_gap, obs_same);
    end
    checks++;
    if (alerts !== 3'b010 || obs_hdr !== exp_hdr) begin
      errors++; $display("FAIL retry_failed: got alerts=%b hdr=%h, want 010 hdr=%h",
                         alerts, obs_hdr, exp_hdr);
    end
    hdr_before = obs_hdr;
    clear_alerts();
    run_txn(8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 0, 2, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_hdr[11:9] !== hdr_before[11:9]) begin
      errors++; $display("FAIL retry_id_kept: got %0d, want %0d", obs_hdr[11:9], hdr_before[11:9]);
    end
  endtask

  task automatic test_wrong_id();
    clear_alerts();
    run_txn(8'h10, 8'($urandom), 8'($urandom), 8'($urandom), 0, int'(CRC) - 1, 1'b0, 1'b1, 3'd5);
    checks++;
    if (obs_starts !== 1 || obs_hung || alerts !== 3'b001) begin
      errors++; $display("FAIL wrong_id: got starts=%0d hung=%b alerts=%b, want 1 0 001",
                         obs_starts, obs_hung, alerts);
    end
  endtask

  task automatic test_discard();
    clear_alerts();
    run_txn(8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b1, 1'b0, 3'd0);
    checks++;
    if (obs_starts !== 0 || obs_hung || alerts !== 3'b100) begin
      errors++; $display("FAIL discard_rx: got starts=%0d alerts=%b, want 0 100",
                         obs_starts, alerts);
    end
    clear_alerts();
    run_txn(8'h07, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_starts !== 0 || alerts !== 3'b100) begin
      errors++; $display("FAIL discard_sop7: got starts=%0d alerts=%b, want 0 100",
                         obs_starts, alerts);
    end
    clear_alerts();
    run_txn(8'h05, 8'($urandom), 8'($urandom), 8'($urandom), -1, 0, 1'b1, 1'b0, 3'd0);
    checks++;
    if (obs_starts !== 1 || obs_hung || alerts !== 3'b001) begin
      errors++; $display("FAIL hard_reset_not_discarded: got starts=%0d alerts=%b, want 1 001",
                         obs_starts, alerts);
    end
  endtask

  task automatic test_hard_reset();
    for (int i = 0; i < 8 && msg_id_m[0] != 3; i++) begin
      run_txn(8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1, 1'b0, 1'b0, 3'd0);
    end
    run_txn(8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 0, 1, 1'b0, 1'b0, 3'd0);
    run_txn(8'h00, 8'($urandom), 8'($urandom), 8'($urandom), -1, 0, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_hdr[11:9] !== 3'd3) begin
      errors++; $display("FAIL hard_reset_setup_id: got %0d, want 3", obs_hdr[11:9]);
    end
    clear_alerts();
    run_txn(8'h06, 8'($urandom), 8'($urandom), 8'($urandom), -1, 0, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_starts !== 1 || obs_hung || alerts !== 3'b001) begin
      errors++; $display("FAIL hard_reset_success: got starts=%0d alerts=%b, want 1 001",
                         obs_starts, alerts);
    end
    run_txn(8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_hdr[11:9] !== 3'd0) begin
      errors++; $display("FAIL hard_reset_sop_id: got %0d, want 0", obs_hdr[11:9]);
    end
    run_txn(8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_hdr[11:9] !== 3'd0) begin
      errors++; $display("FAIL hard_reset_sop1_id: got %0d, want 0", obs_hdr[11:9]);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 9; k++) begin
      run_txn(8'h02, 8'($urandom), 8'($urandom), 8'($urandom), 0, k, 1'b0, 1'b0, 3'd0);
      checks++;
      if (obs_hdr[11:9] !== 3'(k % 8) || obs_hdr !== exp_hdr) begin
        errors++; $display("FAIL wrap_id[%0d]: got hdr=%h, want id %0d hdr=%h",
                           k, obs_hdr, k % 8, exp_hdr);
      end
    end
  endtask

  task automatic test_alert_clear();
    int n;
    clear_alerts();
    transmit = 8'h05; transmit_write = 1'b1;
    tick();
    transmit_write = 1'b0;
    n = 0;
    while (!phy_tx_start && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (!phy_tx_start) begin
      errors++; $display("FAIL alert_clear_start: got no phy_tx_start, want one");
    end
    tick();
    phy_tx_done = 1'b1;
    tick();
    phy_tx_done = 1'b0;
    msg_id_m = '{0, 0, 0};
    alert_clear = 3'b001;
    tick();
    checks++;
    if (succ !== 1'b1) begin
      errors++; $display("FAIL alert_set_beats_clear: got %b, want 1", succ);
    end
    tick();
    alert_clear = 3'b000;
    checks++;
    if (succ !== 1'b0) begin
      errors++; $display("FAIL alert_clear_next: got %b, want 0", succ);
    end
  endtask

  task automatic test_random();
    int sops [6] = '{0, 1, 2, 5, 6, 7};
    logic [7:0] tr;
    for (int i = 0; i < 14; i++) begin
      tr = {2'b00, 2'($urandom), 1'b0, 3'(sops[$urandom_range(0, 5)])};
      clear_alerts();
      run_txn(tr, 8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)) - 1,
              int'($urandom_range(1, CRC - 1)), ($urandom_range(0, 3) == 0),
              1'($urandom), 3'($urandom_range(1, 7)));
      checks++;
      if (obs_hung || obs_starts !== exp_starts || alerts !== exp_set) begin
        errors++; $display("FAIL random[%0d] tr=%h: got starts=%0d alerts=%b hung=%b, want %0d %b",
                           i, tr, obs_starts, alerts, obs_hung, exp_starts, exp_set);
      end
      if (exp_starts > 0) begin
        checks++;
        if (obs_hdr !== exp_hdr || !obs_same || obs_bad_gap != 0 || obs_lat != 2) begin
          errors++;
          $display("FAIL random_hdr[%0d]: got hdr=%h same=%b gaps=%0d lat=%0d, want hdr=%h",
                   i, obs_hdr, obs_same, obs_bad_gap, obs_lat, exp_hdr);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    clear_alerts();
    run_txn(8'h02, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0, 3'd0);
    hdr_info = 8'hFF; byte0 = 8'hFF; byte1 = 8'hF0;
    transmit = 8'h02; transmit_write = 1'b1;
    tick();
    transmit_write = 1'b0;
    n = 0;
    while (!phy_tx_start && n < 10) begin
      tick();
      n++;
    end
    tick();
    phy_tx_done = 1'b1;
    tick();
    phy_tx_done = 1'b0;
    repeat (5) tick();
    checks++;
    if (tx_busy !== 1'b1 || succ !== 1'b1) begin
      errors++; $display("FAIL midflight_setup: got busy=%b succ=%b, want 1 1", tx_busy, succ);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({phy_tx_start, phy_tx_sop, tx_header, tx_busy, alerts} !== 24'd0) begin
      errors++;
      $display("FAIL midflight_reset: got start=%b sop=%0d hdr=%h busy=%b alerts=%b, want all 0",
               phy_tx_start, phy_tx_sop, tx_header, tx_busy, alerts);
    end
    tick();
    reset = 1'b1;
    msg_id_m = '{0, 0, 0};
    tick();
    run_txn(8'h02, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0, 3'd0);
    checks++;
    if (obs_hdr !== exp_hdr || obs_hdr[11:9] !== 3'd0 || alerts !== 3'b001) begin
      errors++; $display("FAIL post_reset_txn: got hdr=%h alerts=%b, want hdr=%h alerts=001",
                         obs_hdr, alerts, exp_hdr);
    end
  endtask

  initial begin
    test_reset();
    test_success();
    test_retries();
    test_wrong_id();
    test_discard();
    test_hard_reset();
    test_wrap();
    test_alert_clear();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
